neuron_dispatch: RTL and testbench
==================================

# neuron_dispatch

Job sequencer that drives the CORDIC neuron from the initiator side. It buffers operand jobs (x, y, z-init, activation select) in a small FIFO and launches each one on the neuron. It then waits for the neuron's completion flag, captures the activation result, and presents it on a valid/ready output. It sits between the layer controller / weight streamer and one neuron instance, and adds a timeout so a hung CORDIC iteration cannot stall the layer.

## Interface
Parameters:
- WIDTH, 15, MSB index of data words; buses are WIDTH+1 bits, fixed-point with 1.0 = 0x0400
- DEPTH, 4, job FIFO entries (power of two, ≥2)
- TIMEOUT, 255, maximum WAIT cycles before a job is aborted (≥2)

Ports:
- clk  in  1  clock, rising edge
- ext_reset  in  1  asynchronous, active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  FIFO can accept a job
- in_x, in_y, in_z  in  WIDTH+1 each  job operands
- in_sel  in  2  activation: 00 sigmoid, 01 tanh, 10 relu
- neu_x, neu_y, neu_z  out  WIDTH+1 each  operands to neuron
- neu_sel  out  2  activation select to neuron
- neu_start  out  1  one-cycle launch pulse to neuron
- neu_complete  in  1  neuron result valid (level)
- neu_result  in  WIDTH+1  neuron activation output
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH+1  captured result
- out_sel  out  2  sel of the job that produced out_data
- out_err  out  1  1 = job timed out, out_data forced to 0
- busy  out  1  state ≠ IDLE or FIFO non-empty
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO entry holds {x, y, z, sel}.
- Push when in_valid & in_ready. in_ready = (count < DEPTH); there is no pop-bypass when full.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE: if count > 0, pop head into the neu_x/neu_y/neu_z/neu_sel registers and go to LAUNCH.
- LAUNCH: neu_start = 1 for exactly this cycle, then go to WAIT. The neu_* outputs stay stable from LAUNCH until DONE is entered.
- WAIT: timer is cleared on entry and increments every cycle.
  - neu_complete is ignored on the first WAIT cycle (stale-level guard) and sampled from the second WAIT cycle on.
  - If neu_complete is sampled high: out_data ← neu_result, out_err ← 0, go to DONE.
  - Else, if timer == TIMEOUT−1: out_data ← 0, out_err ← 1, go to DONE.
  - If complete and timeout occur in the same cycle, complete wins.
- DONE: out_valid = 1 and out_data/out_sel/out_err are held stable. On out_ready, go to IDLE; out_valid is 0 the following cycle.
- neu_complete is ignored in every state other than WAIT.
- Pushes are accepted in every state; the FIFO fills while a job runs.
- Jobs are processed strictly in order; one job is in flight at a time.

## Timing
- Reset (ext_reset low, asynchronous):
  - state IDLE, FIFO empty, count 0.
  - All outputs 0, including in_ready.
  - in_ready rises in the first cycle after reset is released.
- Push at edge N into an idle, empty block:
  - IDLE sees count = 1 in cycle N+1.
  - LAUNCH (neu_start high) in cycle N+2.
  - WAIT begins in cycle N+3.
- neu_complete sampled at edge M in WAIT → out_valid high from cycle M+1.
- A timeout with no complete gives out_valid TIMEOUT+3 cycles after the push (empty/idle start).
- Minimum job-to-job spacing at neu_start: 5 cycles (LAUNCH, 2×WAIT, DONE with out_ready already high, IDLE).
- count updates on the edge following a push or pop. Simultaneous push and pop leaves count unchanged.
- Reset mid-operation discards the FIFO, any in-flight job, and any held result. neu_start is never re-issued for a discarded job.

## Test plan
- Single job: push x=0x0400, y=0x0200, z=0, sel=01; neuron model completes 20 cycles after neu_start with 0x0123. Required: neu_start is one-cycle high at push+2; out_valid at the completion edge +1 with out_data=0x0123, out_sel=01, out_err=0.
- Fill/backpressure: push 5 jobs back-to-back with out_ready=1 and neuron latency 10. Required: in_ready low once count=4; the 5th job is accepted only after the first pop; results come out in push order.
- Timeout: neuron never completes. Required: out_valid with out_data=0 and out_err=1 exactly TIMEOUT+3 cycles after the push; the next queued job then launches normally.
- Stale complete: hold neu_complete high through LAUNCH and the first WAIT cycle, then drop it, then assert it at WAIT cycle 5. Required: the result is captured at WAIT cycle 5, not at cycle 1.
- Output stall: out_ready=0 for 30 cycles with 2 jobs queued. Required: out_* held stable, no second neu_start until out_ready; the second job launches 2 cycles after the handshake.
- Reset mid-WAIT: assert ext_reset low during WAIT with 3 jobs queued. Required: all outputs 0 immediately and count=0; after release, no neu_start without a new push.

Source files
------------

// File: rtl/neuron_dispatch.sv
// Job sequencer for one CORDIC neuron. Operand jobs are queued in a FIFO and
// launched one at a time. The completion result, or a timeout error, is
// returned on a valid/ready output.
module neuron_dispatch #(
    parameter int unsigned WIDTH   = 15,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       ext_reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH:0]             in_x,
    input  logic [WIDTH:0]             in_y,
    input  logic [WIDTH:0]             in_z,
    input  logic [1:0]                 in_sel,
    output logic [WIDTH:0]             neu_x,
    output logic [WIDTH:0]             neu_y,
    output logic [WIDTH:0]             neu_z,
    output logic [1:0]                 neu_sel,
    output logic                       neu_start,
    input  logic                       neu_complete,
    input  logic [WIDTH:0]             neu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH:0]             out_data,
    output logic [1:0]                 out_sel,
    output logic                       out_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned EW = 3 * W1 + 2;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StDone
    } state_e;

    state_e         r_state;
    state_e         w_state_nxt;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_nxt;
    logic           r_in_ready;
    logic [EW-1:0]  w_head;
    logic           w_push;
    logic           w_pop;

    logic [TW-1:0]  r_timer;
    logic           w_capture;
    logic           w_timeout;

    logic [WIDTH:0] r_neu_x;
    logic [WIDTH:0] r_neu_y;
    logic [WIDTH:0] r_neu_z;
    logic [1:0]     r_neu_sel;
    logic [WIDTH:0] r_out_data;
    logic [1:0]     r_out_sel;
    logic           r_out_err;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_state == StIdle) && (r_count != '0);
    assign w_head = r_mem[r_rptr];

    // FIFO occupancy after this edge; push and pop together cancel out
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // FIFO storage; no reset needed because the pointers decide what is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_x, in_y, in_z, in_sel};
        end
    end

    // FIFO pointers, count and registered in_ready (held low during reset)
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    // Next-state logic; timer value 0 marks the first WAIT cycle (stale guard)
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_count != '0) w_state_nxt = StLaunch;
            end
            StLaunch: begin
                w_state_nxt = StWait;
            end
            StWait: begin
                if ((r_timer != '0) && neu_complete) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StDone;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (out_ready) w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State register and WAIT timer (cleared in LAUNCH so it is 0 on WAIT entry)
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_state <= StIdle;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StLaunch) begin
                r_timer <= '0;
            end else if (r_state == StWait) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Operand registers, loaded on pop and held through LAUNCH and WAIT
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_neu_x   <= '0;
            r_neu_y   <= '0;
            r_neu_z   <= '0;
            r_neu_sel <= '0;
        end else if (w_pop) begin
            r_neu_x   <= w_head[3*W1+1 -: W1];
            r_neu_y   <= w_head[2*W1+1 -: W1];
            r_neu_z   <= w_head[W1+1 -: W1];
            r_neu_sel <= w_head[1:0];
        end
    end

    // Result capture on completion or timeout; held while DONE waits
    always_ff @(posedge clk or negedge ext_reset) begin
        if (!ext_reset) begin
            r_out_data <= '0;
            r_out_sel  <= '0;
            r_out_err  <= 1'b0;
        end else if (w_capture) begin
            r_out_data <= neu_result;
            r_out_sel  <= r_neu_sel;
            r_out_err  <= 1'b0;
        end else if (w_timeout) begin
            r_out_data <= '0;
            r_out_sel  <= r_neu_sel;
            r_out_err  <= 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign neu_x     = r_neu_x;
    assign neu_y     = r_neu_y;
    assign neu_z     = r_neu_z;
    assign neu_sel   = r_neu_sel;
    assign neu_start = (r_state == StLaunch);
    assign out_valid = (r_state == StDone);
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_err   = r_out_err;
    assign busy      = (r_state != StIdle) || (r_count != '0);
    assign count     = r_count;

endmodule

// File: tb/tb_neuron_dispatch.sv
// Randomized bench for neuron_dispatch: a cycle-level job model predicts launch
// cycles, result timing and values from the job queue and the neuron latency.
module tb_neuron_dispatch;

    localparam int unsigned WIDTH   = 15;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            ext_reset;
    logic            in_valid;
    logic            in_ready;
    logic [WIDTH:0]  in_x, in_y, in_z;
    logic [1:0]      in_sel;
    logic [WIDTH:0]  neu_x, neu_y, neu_z;
    logic [1:0]      neu_sel;
    logic            neu_start;
    logic            neu_complete;
    logic [WIDTH:0]  neu_result;
    logic            out_valid;
    logic            out_ready;
    logic [WIDTH:0]  out_data;
    logic [1:0]      out_sel;
    logic            out_err;
    logic            busy;
    logic [CW-1:0]   count;

    neuron_dispatch #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .ext_reset    (ext_reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .in_sel       (in_sel),
        .neu_x        (neu_x),
        .neu_y        (neu_y),
        .neu_z        (neu_z),
        .neu_sel      (neu_sel),
        .neu_start    (neu_start),
        .neu_complete (neu_complete),
        .neu_result   (neu_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .out_err      (out_err),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [1:0]  sel;
        int          pc;
    } job_t;

    job_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Stimulus knobs
    int          n_push;
    int          p_push;
    int          p_rdy;
    int          lat_fix;
    int          stale_fix;
    bit          res_is_fix;
    logic [15:0] res_fix;
    bit          use_fix;
    job_t        fix_job;

    // Model of the job in flight
    bit          active;
    int          st;
    int          lat;
    int          vcyc;
    int          free_cyc;
    bit          stale;
    logic [15:0] res;
    job_t        cur;
    logic [15:0] exp_data;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_neu_start", neu_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel_err", {out_sel, out_err}, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_neu_xy", {neu_x, neu_y}, 0);
        check("rst_neu_zsel", {neu_z, neu_sel}, 0);
    endtask

    // One clock cycle: sample at negedge, compare to model, drive next inputs
    task automatic step();
        int   exp_st;
        int   eff;
        bit   ok;
        job_t j;
        @(negedge clk);
        cyc++;
        exp_st = 0;
        if (!active && q.size() > 0) exp_st = imax(free_cyc, q[0].pc + 2);

        if (neu_start) begin
            if (active || q.size() == 0) begin
                check("spurious_start", neu_start, 0);
            end else begin
                check("start_cycle", cyc, exp_st);
                cur    = q.pop_front();
                active = 1'b1;
                st     = cyc;
                lat    = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, TIMEOUT + 4));
                stale  = (stale_fix >= 0) ? stale_fix[0] : $urandom_range(0, 1) == 1;
                res    = res_is_fix ? res_fix : 16'($urandom);
                eff    = imax(lat, 2);
                ok     = eff <= TIMEOUT;
                vcyc   = ok ? st + eff + 1 : st + int'(TIMEOUT) + 1;
                exp_data = ok ? res : 16'h0;
                exp_err  = !ok;
            end
        end else if (!active && q.size() > 0 && cyc == exp_st) begin
            check("start_missing", neu_start, 1);
        end

        if (active) begin
            if (cyc < vcyc) begin
                check("valid_early", out_valid, 0);
                check("neu_xy", {neu_x, neu_y}, {cur.x, cur.y});
                check("neu_zsel", {neu_z, neu_sel}, {cur.z, cur.sel});
            end else begin
                check("valid", out_valid, 1);
                check("out_data", out_data, exp_data);
                check("out_sel_err", {out_sel, out_err}, {cur.sel, exp_err});
            end
        end else begin
            check("valid_idle", out_valid, 0);
        end

        check("count", count, q.size());
        check("in_ready", in_ready, q.size() < DEPTH);
        check("busy", busy, active || q.size() > 0);

        // Neuron model: level complete, LAUNCH and first WAIT cycle carry the stale level
        if (active) begin
            if (cyc <= st + 1) neu_complete = stale;
            else               neu_complete = (cyc >= st + lat);
            neu_result = res;
        end else begin
            neu_complete = $urandom_range(0, 1) == 1;
            neu_result   = 16'($urandom);
        end

        out_ready = $urandom_range(0, 99) < p_rdy;
        if (active && cyc >= vcyc && out_ready) begin
            active   = 1'b0;
            free_cyc = cyc + 2;
        end

        in_valid = (n_push > 0) && ($urandom_range(0, 99) < p_push);
        if (use_fix) begin
            j = fix_job;
        end else begin
            j.x   = 16'($urandom);
            j.y   = 16'($urandom);
            j.z   = 16'($urandom);
            j.sel = 2'($urandom_range(0, 2));
        end
        in_x   = j.x;
        in_y   = j.y;
        in_z   = j.z;
        in_sel = j.sel;
        if (in_valid && q.size() < DEPTH) begin
            j.pc = cyc;
            q.push_back(j);
            n_push--;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        n_push = 0;
        p_rdy  = 100;
        for (int i = 0; i < 600; i++) begin
            if (!active && q.size() == 0) break;
            step();
        end
        check("drain", active || q.size() > 0, 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        ext_reset = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        active   = 1'b0;
        free_cyc = 0;
        n_push   = 0;
        @(negedge clk);
        cyc++;
        check_reset_outputs();
        ext_reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_reset    = 1'b0;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        in_z         = '0;
        in_sel       = '0;
        neu_complete = 1'b0;
        neu_result   = '0;
        out_ready    = 1'b0;
        n_push = 0; p_push = 100; p_rdy = 100; lat_fix = 0; stale_fix = 0;
        res_is_fix = 1'b0; res_fix = '0; use_fix = 1'b0;
        active = 1'b0; st = 0; lat = 0; vcyc = 0; free_cyc = 0; stale = 1'b0;
        fix_job = '{x: 16'h0400, y: 16'h0200, z: 16'h0000, sel: 2'b01, pc: 0};

        #2;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        ext_reset = 1'b1;

        // Single job with fixed latency and result
        use_fix = 1'b1; n_push = 1; lat_fix = 20; res_is_fix = 1'b1; res_fix = 16'h0123;
        run(35);
        drain();
        use_fix = 1'b0; res_is_fix = 1'b0;

        // Fill and backpressure
        n_push = 5; p_push = 100; lat_fix = 10;
        run(10);
        drain();

        // Timeout, then the next queued job
        n_push = 2; lat_fix = TIMEOUT + 10;
        run(5);
        drain();

        // Stale complete held through LAUNCH and first WAIT cycle
        n_push = 1; lat_fix = 5; stale_fix = 1;
        run(5);
        drain();

        // Output stall with two jobs queued
        n_push = 2; lat_fix = 3; stale_fix = 0; p_rdy = 0;
        run(30);
        drain();

        // Randomized traffic
        lat_fix = 0; stale_fix = -1; n_push = 1_000_000; p_push = 40; p_rdy = 60;
        run(3000);
        drain();

        // Reset in WAIT with three jobs queued
        n_push = 4; p_push = 100; lat_fix = TIMEOUT + 10; p_rdy = 100;
        for (int i = 0; i < 40; i++) begin
            step();
            if (active && cyc >= st + 2 && q.size() == 3) break;
        end
        check("reach_wait", active && q.size() == 3, 1);
        do_reset();
        run(20);

        // Recovery after reset
        lat_fix = 0; stale_fix = -1; n_push = 6; p_push = 50; p_rdy = 70;
        run(100);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
